alu_cdb_producer: RTL and testbench

- Integer ALU execute unit and result buffer on the issue side of the backend.
- Accepts one issued ALU op per cycle under the alu_ex_ready handshake and computes the RV32I result.
- Buffers results in a small in-order FIFO.
- Requests the common data bus and broadcasts {tag, data} when granted; this is the producer of cdb_in as seen by the backend.

---
 rtl/alu_cdb_if.sv | 35 +++
 rtl/alu_cdb_producer.sv | 91 +++++++++
 tb/tb_alu_cdb_producer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_cdb_if.sv
// alu_cdb_if: issue-side and CDB-side signals of the ALU result producer.
// slave is the ALU unit. It receives the issued op, flush and the grant, and it drives
// ready, the CDB request/broadcast and busy. master is the issuer/arbiter side.
interface alu_cdb_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
);
    logic              issue_valid;
    logic              alu_ex_ready;
    logic [DATA_W-1:0] alu_op_a;
    logic [DATA_W-1:0] alu_op_b;
    logic [6:0]        alu_opcode;
    logic [2:0]        alu_funct3;
    logic              alu_funct7_b5;
    logic [TAG_W-1:0]  alu_p_dest;
    logic              flush;
    logic              cdb_req;
    logic              cdb_grant;
    logic              cdb_out_valid;
    logic [TAG_W-1:0]  cdb_out_tag;
    logic [DATA_W-1:0] cdb_out_data;
    logic              busy;

    modport master (
        output issue_valid, alu_op_a, alu_op_b, alu_opcode, alu_funct3, alu_funct7_b5,
               alu_p_dest, flush, cdb_grant,
        input  alu_ex_ready, cdb_req, cdb_out_valid, cdb_out_tag, cdb_out_data, busy
    );

    modport slave (
        input  issue_valid, alu_op_a, alu_op_b, alu_opcode, alu_funct3, alu_funct7_b5,
               alu_p_dest, flush, cdb_grant,
        output alu_ex_ready, cdb_req, cdb_out_valid, cdb_out_tag, cdb_out_data, busy
    );
endinterface

// File: rtl/alu_cdb_producer.sv
// alu_cdb_producer: RV32I integer ALU with an in-order result FIFO that broadcasts {tag, data} on the CDB.
// Ports: clk and reset are plain ports, and reset is asynchronous and active-high.
// bus (alu_cdb_if.slave) carries the following groups:
//   - the issue handshake and operands (issue_valid/alu_ex_ready, op_a/op_b, opcode, funct3, funct7_b5, p_dest)
//   - flush
//   - the CDB request/grant
//   - the broadcast outputs and busy
module alu_cdb_producer #(
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 6,
    parameter int FIFO_DEPTH = 2
) (
    input logic     clk,
    input logic     reset,
    alu_cdb_if.slave bus
);
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(DATA_W);
    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic [CW-1:0]     count;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [TAG_W-1:0]  tag_mem  [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] a, b, alu, result;
    logic [SW-1:0]     shamt;
    logic              sub, accept, push, pop;

    assign a     = bus.alu_op_a;
    assign b     = bus.alu_op_b;
    assign shamt = b[SW-1:0];
    // Only the register form subtracts; the immediate form's bit 30 belongs to the immediate.
    assign sub   = bus.alu_funct7_b5 & (bus.alu_opcode == OP_R);

    always_comb begin
        case (bus.alu_funct3)
            3'b000:  alu = sub ? a - b : a + b;
            3'b001:  alu = a << shamt;
            3'b010:  alu = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            3'b011:  alu = {{(DATA_W-1){1'b0}}, a < b};
            3'b100:  alu = a ^ b;
            3'b101:  alu = bus.alu_funct7_b5 ? $unsigned($signed(a) >>> shamt) : a >> shamt;
            3'b110:  alu = a | b;
            default: alu = a & b;
        endcase
        result = (bus.alu_opcode == OP_R || bus.alu_opcode == OP_I) ? alu :
                 bus.alu_opcode == OP_LUI   ? b :
                 bus.alu_opcode == OP_AUIPC ? a + b : '0;
    end

    assign bus.alu_ex_ready  = (count < FULL) & ~reset;
    assign bus.busy          = count != '0;
    assign bus.cdb_req       = bus.busy & ~bus.flush;
    assign bus.cdb_out_valid = bus.cdb_req & bus.cdb_grant;
    assign bus.cdb_out_tag   = bus.cdb_out_valid ? tag_mem[rd_ptr] : '0;
    assign bus.cdb_out_data  = bus.cdb_out_valid ? data_mem[rd_ptr] : '0;

    assign accept = bus.issue_valid & bus.alu_ex_ready & ~bus.flush;
    // An op that writes p0 takes its issue slot, but nothing is ever broadcast for it.
    assign push   = accept & (bus.alu_p_dest != '0);
    assign pop    = bus.cdb_out_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (bus.flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr]  <= bus.alu_p_dest;
            data_mem[wr_ptr] <= result;
        end
    end
endmodule

// File: tb/tb_alu_cdb_producer.sv
// tb_alu_cdb_producer: scoreboard bench for alu_cdb_producer with directed corners and randomized traffic.
module tb_alu_cdb_producer;
    localparam int DEPTH = 2;
    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LUI = 7'b0110111, AUIPC = 7'b0010111;

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] data;
    } ent_t;

    logic clk = 0, reset = 1, rand_mode = 0;
    int checks = 0, failures = 0;
    ent_t q[$];

    alu_cdb_if #(.DATA_W(32), .TAG_W(6)) ifc ();
    alu_cdb_producer #(.DATA_W(32), .TAG_W(6), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(ifc));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned sh = b[4:0];
        if (op == LUI) return b;
        if (op == AUIPC) return a + b;
        if (op != R && op != I) return 0;
        case (f3)
            3'd0: return (op == R && f7) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ((a ^ 32'h80000000) < (b ^ 32'h80000000)) ? 1 : 0;
            3'd3: return (a < b) ? 1 : 0;
            3'd4: return a ^ b;
            3'd5: return (a >> sh) | ((f7 && a[31]) ? ~(32'hFFFFFFFF >> sh) : 32'h0);
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag,
                         input logic [31:0] exp);
        bit acc = 0;
        int n = 0;
        ifc.issue_valid = 1; ifc.alu_opcode = op; ifc.alu_funct3 = f3; ifc.alu_funct7_b5 = f7;
        ifc.alu_op_a = a; ifc.alu_op_b = b; ifc.alu_p_dest = tag;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = ifc.alu_ex_ready && !ifc.flush;
            @(posedge clk);
            n++;
            if (acc && tag != 0) q.push_back('{tag, exp});
        end
        #1 ifc.issue_valid = 0;
        if (!acc) begin
            checks++; failures++;
            $display("FAIL accept_timeout: tag %0d not accepted within 100 cycles", tag);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        check("drain_left", q.size(), 0);
    endtask

    always @(posedge clk) if (ifc.flush) q.delete();

    always @(posedge clk) if (rand_mode) begin
        #1;
        ifc.cdb_grant = 1'($urandom);
        ifc.flush = ($urandom_range(0, 15) == 0);
    end

    always @(negedge clk) if (!reset) begin
        ent_t e;
        logic exp_req;
        exp_req = q.size() != 0 && !ifc.flush;
        check("busy", ifc.busy, q.size() != 0);
        check("ready", ifc.alu_ex_ready, q.size() < DEPTH);
        check("cdb_req", ifc.cdb_req, exp_req);
        check("cdb_valid", ifc.cdb_out_valid, exp_req && ifc.cdb_grant);
        if (ifc.cdb_out_valid === 1'b1) begin
            if (q.size() == 0) check("unexpected_bcast", 1, 0);
            else begin
                e = q.pop_front();
                check("cdb_tag", ifc.cdb_out_tag, e.tag);
                check("cdb_data", ifc.cdb_out_data, e.data);
            end
        end else check("idle_bus", {ifc.cdb_out_tag, ifc.cdb_out_data}, 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a, b;
        logic [5:0]  tag;
        int gap;
        ifc.issue_valid = 0; ifc.alu_op_a = 0; ifc.alu_op_b = 0; ifc.alu_opcode = 0;
        ifc.alu_funct3 = 0; ifc.alu_funct7_b5 = 0; ifc.alu_p_dest = 0; ifc.flush = 0; ifc.cdb_grant = 1;
        #3;
        check("rst_ready", ifc.alu_ex_ready, 0);
        check("rst_outs", {ifc.cdb_req, ifc.cdb_out_valid, ifc.busy}, 0);
        #9 reset = 0;
        @(posedge clk); #1;
        check("ready_after_rst", ifc.alu_ex_ready, 1);

        issue(R, 3'b000, 0, 10, 20, 3, 30);
        issue(R, 3'b000, 1, 5, 7, 8, 32'hFFFFFFFE);
        issue(R, 3'b101, 1, 32'h80000000, 4, 9, 32'hF8000000);
        issue(I, 3'b101, 0, 32'h80000000, 4, 10, 32'h08000000);
        issue(R, 3'b011, 0, 1, 32'hFFFFFFFF, 11, 1);
        issue(R, 3'b010, 0, 1, 32'hFFFFFFFF, 12, 0);
        issue(LUI, 3'b000, 0, 32'hDEADBEEF, 32'h12345000, 13, 32'h12345000);
        issue(AUIPC, 3'b000, 0, 32'h1000, 32'h2000, 14, 32'h3000);
        issue(I, 3'b000, 1, 5, 7, 15, 12);
        issue(7'b1100011, 3'b000, 0, 5, 7, 16, 0);
        drain();

        issue(R, 3'b000, 0, 1, 1, 0, 2);
        repeat (3) @(posedge clk); #1;

        ifc.cdb_grant = 0;
        issue(R, 3'b000, 0, 1, 2, 4, 3);
        issue(R, 3'b000, 0, 3, 4, 5, 7);
        fork
            issue(R, 3'b000, 0, 5, 6, 6, 11);
            begin repeat (3) @(posedge clk); #1 ifc.cdb_grant = 1; end
        join
        drain();

        ifc.cdb_grant = 0;
        issue(R, 3'b110, 0, 32'hF0, 32'h0F, 20, 32'hFF);
        issue(R, 3'b111, 0, 32'hF0, 32'h3C, 21, 32'h30);
        ifc.flush = 1; ifc.issue_valid = 1; ifc.alu_p_dest = 22;
        @(posedge clk); #1;
        ifc.flush = 0; ifc.issue_valid = 0;
        ifc.cdb_grant = 1;
        repeat (2) @(posedge clk); #1;

        ifc.cdb_grant = 0;
        issue(R, 3'b100, 0, 32'hFF, 32'h0F, 30, 32'hF0);
        issue(R, 3'b001, 0, 1, 35, 31, 8);
        #1;
        reset = 1; ifc.cdb_grant = 1;
        #1;
        check("arst_valid", ifc.cdb_out_valid, 0);
        check("arst_req", ifc.cdb_req, 0);
        check("arst_busy", ifc.busy, 0);
        check("arst_ready", ifc.alu_ex_ready, 0);
        q.delete();
        #5 reset = 0;
        @(posedge clk); #1;
        check("post_rst_busy", ifc.busy, 0);
        issue(R, 3'b000, 0, 100, 23, 7, 123);
        drain();

        rand_mode = 1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0, 1: op = R;
                2: op = I;
                3: op = LUI;
                4: op = AUIPC;
                default: op = 7'($urandom);
            endcase
            f3 = 3'($urandom); f7 = 1'($urandom); a = $urandom; b = $urandom;
            tag = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            issue(op, f3, f7, a, b, tag, ref_alu(op, f3, f7, a, b));
            gap = $urandom_range(0, 2);
            repeat (gap) @(posedge clk);
            if (gap != 0) #1;
        end
        rand_mode = 0;
        @(posedge clk); #2;
        ifc.cdb_grant = 1; ifc.flush = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
